// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch stage.
package fetch_pkg;

    localparam int unsigned XLEN = 32;

    typedef logic [XLEN-1:0] word_t;

    localparam word_t DefaultResetPc  = 32'h0000_0000;
    localparam word_t DefaultNopWord  = 32'h0000_0000;

    // FETCH: request outstanding, HOLD: stalled with a word parked in the skid,
    // DRAIN: waiting out a fetch that a redirect made stale.
    typedef enum logic [1:0] {
        StFetch = 2'd0,
        StHold  = 2'd1,
        StDrain = 2'd2
    } fetch_state_e;

    // Redirect targets are always word aligned.
    function automatic word_t align_target(input word_t target);
        return target & ~word_t'(32'h3);
    endfunction

endpackage

// File: rtl/instruction_fetch_stage_if.sv
// Instruction-memory request/acknowledge bus.
interface instruction_fetch_stage_if;
    import fetch_pkg::*;

    logic  IMemReq;
    logic  IMemAddr_unused_guard;
    word_t IMemAddr;
    logic  IMemAck;
    word_t IMemData;

    // Fetch stage side.
    modport master (
        output IMemReq,
        output IMemAddr,
        input  IMemAck,
        input  IMemData
    );

    // Memory side.
    modport slave (
        input  IMemReq,
        input  IMemAddr,
        output IMemAck,
        output IMemData
    );

endinterface

// File: rtl/fetch_skid_buffer.sv
// One-entry skid buffer holding an instruction word and its PC+4 while the
// decode stage is stalled.
module fetch_skid_buffer
    import fetch_pkg::*;
(
    input  logic  clk_i,
    input  logic  rst_ni,
    input  logic  load_i,
    input  logic  drain_i,
    input  logic  clear_i,
    input  word_t instr_i,
    input  word_t pc_plus4_i,
    output logic  valid_o,
    output word_t instr_o,
    output word_t pc_plus4_o
);

    logic  valid_q, valid_d;
    word_t instr_q, instr_d;
    word_t pc_plus4_q, pc_plus4_d;

    // Next-state: clear/drain empty the entry, load fills it.
    always_comb begin
        valid_d    = valid_q;
        instr_d    = instr_q;
        pc_plus4_d = pc_plus4_q;
        if (clear_i || drain_i) begin
            valid_d    = 1'b0;
            instr_d    = '0;
            pc_plus4_d = '0;
        end else if (load_i) begin
            valid_d    = 1'b1;
            instr_d    = instr_i;
            pc_plus4_d = pc_plus4_i;
        end
    end

    // Entry registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_q    <= 1'b0;
            instr_q    <= '0;
            pc_plus4_q <= '0;
        end else begin
            valid_q    <= valid_d;
            instr_q    <= instr_d;
            pc_plus4_q <= pc_plus4_d;
        end
    end

    assign valid_o    = valid_q;
    assign instr_o    = instr_q;
    assign pc_plus4_o = pc_plus4_q;

endmodule

// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: PC register, fetch FSM and IF/ID pipeline register.
// One fetch outstanding at a time; redirects flush IF/ID and take priority
// over stalls.
module instruction_fetch_stage
    import fetch_pkg::*;
#(
    parameter word_t RESET_PC = DefaultResetPc,
    parameter word_t NOP_WORD = DefaultNopWord
) (
    input  logic                       Clk,
    input  logic                       Rst,
    input  logic                       Stall,
    input  logic                       PCSrc,
    input  word_t                      BranchTarget,
    instruction_fetch_stage_if.master  imem,
    output word_t                      Instruction,
    output word_t                      PCPlus4,
    output logic                       InstrValid
);

    fetch_state_e state_q, state_d;
    word_t        pc_q, pc_d;
    word_t        pend_target_q, pend_target_d;
    word_t        instr_q, instr_d;
    word_t        pc4_q, pc4_d;
    logic         valid_q, valid_d;

    logic  skid_load, skid_drain, skid_clear;
    logic  skid_valid;
    word_t skid_instr, skid_pc4;

    word_t pc_plus4;
    word_t target_aligned;

    assign pc_plus4       = pc_q + 32'd4;
    assign target_aligned = align_target(BranchTarget);

    fetch_skid_buffer u_skid (
        .clk_i      (Clk),
        .rst_ni     (Rst),
        .load_i     (skid_load),
        .drain_i    (skid_drain),
        .clear_i    (skid_clear),
        .instr_i    (imem.IMemData),
        .pc_plus4_i (pc_plus4),
        .valid_o    (skid_valid),
        .instr_o    (skid_instr),
        .pc_plus4_o (skid_pc4)
    );

    // DRAIN keeps requesting the stale address so the old fetch completes.
    always_comb begin
        imem.IMemReq  = (state_q != StHold);
        imem.IMemAddr = pc_q;
    end

    // Next-state logic for FSM, PC, pending target, IF/ID and skid control.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pend_target_d = pend_target_q;
        instr_d       = instr_q;
        pc4_d         = pc4_q;
        valid_d       = valid_q;
        skid_load     = 1'b0;
        skid_drain    = 1'b0;
        skid_clear    = 1'b0;

        unique case (state_q)
            StFetch: begin
                if (PCSrc) begin
                    if (imem.IMemAck) begin
                        pc_d = target_aligned;
                    end else begin
                        pend_target_d = target_aligned;
                        state_d       = StDrain;
                    end
                end else if (imem.IMemAck) begin
                    pc_d = pc_plus4;
                    if (!Stall) begin
                        instr_d = imem.IMemData;
                        pc4_d   = pc_plus4;
                        valid_d = 1'b1;
                    end else begin
                        skid_load = 1'b1;
                        state_d   = StHold;
                    end
                end
            end
            StHold: begin
                if (PCSrc) begin
                    skid_clear = 1'b1;
                    pc_d       = target_aligned;
                    state_d    = StFetch;
                end else if (!Stall) begin
                    instr_d    = skid_instr;
                    pc4_d      = skid_pc4;
                    valid_d    = skid_valid;
                    skid_drain = 1'b1;
                    state_d    = StFetch;
                end
            end
            StDrain: begin
                if (imem.IMemAck) begin
                    // A redirect arriving with the ack is the newest target.
                    pc_d          = PCSrc ? target_aligned : pend_target_q;
                    pend_target_d = '0;
                    state_d       = StFetch;
                end else if (PCSrc) begin
                    pend_target_d = target_aligned;
                end
            end
            default: begin
                state_d = StFetch;
            end
        endcase

        // Any redirect squashes whatever IF/ID holds, stalled or not.
        if (PCSrc) begin
            instr_d = NOP_WORD;
            pc4_d   = '0;
            valid_d = 1'b0;
        end
    end

    // State, PC and IF/ID registers with synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q       <= StFetch;
            pc_q          <= RESET_PC;
            pend_target_q <= '0;
            instr_q       <= NOP_WORD;
            pc4_q         <= '0;
            valid_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pend_target_q <= pend_target_d;
            instr_q       <= instr_d;
            pc4_q         <= pc4_d;
            valid_q       <= valid_d;
        end
    end

    assign Instruction = instr_q;
    assign PCPlus4     = pc4_q;
    assign InstrValid  = valid_q;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Self-checking bench for instruction_fetch_stage: per-cycle vectors with
// bus checks before the edge and IF/ID expectations queued and popped after it.
module tb_instruction_fetch_stage;
    import fetch_pkg::*;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        pcsrc;
        logic [31:0] tgt;
        logic        ack;
        logic [31:0] data;
        logic        chk_bus;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic [31:0] exp_instr;
        logic [31:0] exp_pc4;
        logic        exp_valid;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
    } ifid_t;

    logic        Clk;
    logic        Rst;
    logic        Stall;
    logic        PCSrc;
    logic [31:0] BranchTarget;
    logic [31:0] Instruction;
    logic [31:0] PCPlus4;
    logic        InstrValid;

    int checks   = 0;
    int failures = 0;

    vec_t  vq[$];
    ifid_t sb[$];

    instruction_fetch_stage_if imem_bus ();

    instruction_fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .NOP_WORD (32'h0000_0000)
    ) dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .Stall        (Stall),
        .PCSrc        (PCSrc),
        .BranchTarget (BranchTarget),
        .imem         (imem_bus),
        .Instruction  (Instruction),
        .PCPlus4      (PCPlus4),
        .InstrValid   (InstrValid)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic vec_t mk(input logic rst, input logic stall, input logic pcsrc,
                                input logic [31:0] tgt, input logic ack,
                                input logic [31:0] data, input logic chk_bus,
                                input logic exp_req, input logic [31:0] exp_addr,
                                input logic [31:0] exp_instr, input logic [31:0] exp_pc4,
                                input logic exp_valid);
        vec_t v;
        v.rst = rst; v.stall = stall; v.pcsrc = pcsrc; v.tgt = tgt;
        v.ack = ack; v.data = data; v.chk_bus = chk_bus; v.exp_req = exp_req;
        v.exp_addr = exp_addr; v.exp_instr = exp_instr; v.exp_pc4 = exp_pc4;
        v.exp_valid = exp_valid;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        ifid_t e;
        Rst               = v.rst;
        Stall             = v.stall;
        PCSrc             = v.pcsrc;
        BranchTarget      = v.tgt;
        imem_bus.IMemAck  = v.ack;
        imem_bus.IMemData = v.data;
        #2;
        if (v.chk_bus) begin
            chk({tag, ".IMemReq"}, {31'd0, imem_bus.IMemReq}, {31'd0, v.exp_req});
            if (v.exp_req) chk({tag, ".IMemAddr"}, imem_bus.IMemAddr, v.exp_addr);
        end
        e.instr = v.exp_instr;
        e.pc4   = v.exp_pc4;
        e.valid = v.exp_valid;
        sb.push_back(e);
        @(posedge Clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s.scoreboard: got empty queue expected one entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, ".Instruction"}, Instruction, e.instr);
            chk({tag, ".PCPlus4"}, PCPlus4, e.pc4);
            chk({tag, ".InstrValid"}, {31'd0, InstrValid}, {31'd0, e.valid});
        end
    endtask

    // Watchdog: the stimulus is finite, so this only fires on a broken run.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        Rst = 1'b0; Stall = 1'b0; PCSrc = 1'b0; BranchTarget = '0;
        imem_bus.IMemAck = 1'b0; imem_bus.IMemData = '0;
        @(posedge Clk);
        #1;

        // rst stall pcsrc tgt ack data chk req addr | instr pc4 valid
        vq.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,  0, 0, 32'h0,        32'h0,  32'h0,   0));
        vq.push_back(mk(1, 0, 0, 32'h0,        1, 32'h11, 1, 1, 32'h0,        32'h11, 32'h4,   1));
        vq.push_back(mk(1, 0, 0, 32'h0,        1, 32'h22, 1, 1, 32'h4,        32'h22, 32'h8,   1));
        vq.push_back(mk(1, 0, 0, 32'h0,        1, 32'h33, 1, 1, 32'h8,        32'h33, 32'hC,   1));
        vq.push_back(mk(1, 1, 0, 32'h0,        1, 32'h44, 1, 1, 32'hC,        32'h33, 32'hC,   1));
        vq.push_back(mk(1, 1, 0, 32'h0,        1, 32'h45, 1, 0, 32'h0,        32'h33, 32'hC,   1));
        vq.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,  1, 0, 32'h0,        32'h44, 32'h10,  1));
        vq.push_back(mk(1, 0, 0, 32'h0,        1, 32'h55, 1, 1, 32'h10,       32'h55, 32'h14,  1));
        vq.push_back(mk(1, 0, 1, 32'h203,      1, 32'h66, 1, 1, 32'h14,       32'h0,  32'h0,   0));
        vq.push_back(mk(1, 0, 0, 32'h0,        1, 32'h77, 1, 1, 32'h200,      32'h77, 32'h204, 1));
        vq.push_back(mk(1, 0, 1, 32'h13,       0, 32'h0,  1, 1, 32'h204,      32'h0,  32'h0,   0));
        vq.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,  1, 1, 32'h204,      32'h0,  32'h0,   0));
        vq.push_back(mk(1, 0, 1, 32'h103,      0, 32'h0,  1, 1, 32'h204,      32'h0,  32'h0,   0));
        vq.push_back(mk(1, 0, 0, 32'h0,        1, 32'h99, 1, 1, 32'h204,      32'h0,  32'h0,   0));
        vq.push_back(mk(1, 0, 0, 32'h0,        1, 32'hA1, 1, 1, 32'h100,      32'hA1, 32'h104, 1));
        vq.push_back(mk(1, 1, 0, 32'h0,        1, 32'hA2, 1, 1, 32'h104,      32'hA1, 32'h104, 1));
        vq.push_back(mk(1, 1, 1, 32'h300,      0, 32'h0,  1, 0, 32'h0,        32'h0,  32'h0,   0));
        vq.push_back(mk(1, 0, 0, 32'h0,        1, 32'hB0, 1, 1, 32'h300,      32'hB0, 32'h304, 1));
        vq.push_back(mk(1, 1, 1, 32'h400,      1, 32'hC0, 1, 1, 32'h304,      32'h0,  32'h0,   0));
        vq.push_back(mk(1, 0, 0, 32'h0,        1, 32'hC1, 1, 1, 32'h400,      32'hC1, 32'h404, 1));
        vq.push_back(mk(1, 0, 1, 32'h500,      0, 32'h0,  1, 1, 32'h404,      32'h0,  32'h0,   0));
        vq.push_back(mk(1, 0, 1, 32'h600,      1, 32'hC2, 1, 1, 32'h404,      32'h0,  32'h0,   0));
        vq.push_back(mk(1, 0, 0, 32'h0,        1, 32'hD0, 1, 1, 32'h600,      32'hD0, 32'h604, 1));
        vq.push_back(mk(1, 0, 1, 32'hFFFFFFFF, 1, 32'hD1, 1, 1, 32'h604,      32'h0,  32'h0,   0));
        vq.push_back(mk(1, 0, 0, 32'h0,        1, 32'hE0, 1, 1, 32'hFFFFFFFC, 32'hE0, 32'h0,   1));
        vq.push_back(mk(1, 0, 0, 32'h0,        1, 32'hE1, 1, 1, 32'h0,        32'hE1, 32'h4,   1));
        vq.push_back(mk(1, 0, 1, 32'h40,       0, 32'h0,  1, 1, 32'h4,        32'h0,  32'h0,   0));
        vq.push_back(mk(0, 0, 0, 32'h0,        1, 32'hF0, 0, 0, 32'h0,        32'h0,  32'h0,   0));
        vq.push_back(mk(1, 0, 0, 32'h0,        1, 32'hF1, 1, 1, 32'h0,        32'hF1, 32'h4,   1));
        vq.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,  1, 1, 32'h4,        32'hF1, 32'h4,   1));

        for (int i = 0; i < vq.size(); i++) begin
            run_vec($sformatf("vec%0d", i), vq[i]);
        end

        // Ack of 0xAA at PC=8 under a three-cycle stall, then release.
        run_vec("hold.rst",  mk(0, 0, 0, 32'h0, 0, 32'h0,  0, 0, 32'h0, 32'h0,  32'h0, 0));
        run_vec("hold.f0",   mk(1, 0, 0, 32'h0, 1, 32'h11, 1, 1, 32'h0, 32'h11, 32'h4, 1));
        run_vec("hold.f4",   mk(1, 0, 0, 32'h0, 1, 32'h22, 1, 1, 32'h4, 32'h22, 32'h8, 1));
        run_vec("hold.f8",   mk(1, 1, 0, 32'h0, 1, 32'hAA, 1, 1, 32'h8, 32'h22, 32'h8, 1));
        run_vec("hold.h1",   mk(1, 1, 0, 32'h0, 1, 32'hBB, 1, 0, 32'h0, 32'h22, 32'h8, 1));
        run_vec("hold.h2",   mk(1, 1, 0, 32'h0, 0, 32'h0,  1, 0, 32'h0, 32'h22, 32'h8, 1));
        run_vec("hold.rel",  mk(1, 0, 0, 32'h0, 0, 32'h0,  1, 0, 32'h0, 32'hAA, 32'hC, 1));
        run_vec("hold.next", mk(1, 0, 0, 32'h0, 0, 32'h0,  1, 1, 32'hC, 32'hAA, 32'hC, 1));

        // Reset while parked in HOLD drops the skid contents.
        run_vec("rh.f",      mk(1, 0, 0, 32'h0, 1, 32'h5A, 1, 1, 32'hC, 32'h5A, 32'h10, 1));
        run_vec("rh.park",   mk(1, 1, 0, 32'h0, 1, 32'h6B, 1, 1, 32'h10, 32'h5A, 32'h10, 1));
        run_vec("rh.rst",    mk(0, 1, 0, 32'h0, 0, 32'h0,  1, 0, 32'h0, 32'h0,  32'h0,  0));
        run_vec("rh.after",  mk(1, 0, 0, 32'h0, 0, 32'h0,  1, 1, 32'h0, 32'h0,  32'h0,  0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_stage.md
INSTRUCTION_FETCH_STAGE -- requirements
Module: instruction_fetch_stage

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter NOP_WORD, 32'h0000_0000, instruction word presented when IF/ID is empty or flushed.
REQ-003 Clk  input  1  single clock; all state updates on rising edge.
REQ-004 Rst  input  1  reset, synchronous and active-low (Rst==0 at rising Clk resets).
REQ-005 Stall  input  1  downstream hazard hold; IF/ID outputs shall not change while high, except on redirect.
REQ-006 PCSrc  input  1  redirect request from branch unit, valid one cycle.
REQ-007 BranchTarget  input  32  redirect address, sampled when PCSrc==1.
REQ-008 IMemReq  output  1  fetch request to instruction memory.
REQ-009 IMemAddr  output  32  fetch address; stable while IMemReq high until IMemAck.
REQ-010 IMemAck  input  1  memory returns IMemData this cycle; ignored when IMemReq low.
REQ-011 IMemData  input  32  fetched instruction word.
REQ-012 Instruction  output  32  IF/ID instruction word feeding the Controller and ALUControl.
REQ-013 PCPlus4  output  32  IF/ID sequential PC of held instruction.
REQ-014 InstrValid  output  1  IF/ID holds a live instruction.

Function
REQ-015 FSM states FETCH, HOLD, DRAIN; reset state FETCH.
REQ-016 FETCH: IMemReq=1, IMemAddr=PC.
REQ-017 FETCH, IMemAck, !Stall, !PCSrc: IF/ID <= {IMemData, PC+4, valid=1}; PC <= PC+4; stay FETCH.
REQ-018 FETCH, IMemAck, Stall, !PCSrc: IMemData and PC+4 captured into skid buffer; PC <= PC+4; IF/ID unchanged; go HOLD.
REQ-019 HOLD: IMemReq=0; when Stall falls, skid moves into IF/ID (valid=1) that edge; go FETCH.
REQ-020 PCSrc in FETCH with IMemAck same cycle: returned word discarded; PC <= BranchTarget; stay FETCH.
REQ-021 PCSrc in FETCH without IMemAck: target stored in PendTarget; go DRAIN.
REQ-022 DRAIN: IMemReq=1 at old address; further PCSrc overwrites PendTarget; on IMemAck data discarded, PC <= latest target (same-cycle PCSrc wins), go FETCH.
REQ-023 PCSrc in HOLD: skid discarded; PC <= BranchTarget; go FETCH.
REQ-024 Any PCSrc cycle: IF/ID flushed (Instruction=NOP_WORD, PCPlus4=0, InstrValid=0) regardless of Stall; PCSrc has priority over Stall.
REQ-025 BranchTarget[1:0] forced to 2'b00 when loaded; PC+4 wraps modulo 2^32.
REQ-026 IF/ID latency: instruction visible on Instruction one cycle after accepting IMemAck edge.
REQ-027 Exactly one outstanding fetch; no new request issued until current one acknowledged.
REQ-028 With Stall low and IMemAck every cycle, throughput is one instruction per cycle.

Reset
REQ-029 On Rst==0: PC=RESET_PC, state=FETCH, Instruction=NOP_WORD, PCPlus4=0, InstrValid=0, skid and PendTarget cleared.
REQ-030 Reset mid-fetch or in DRAIN/HOLD abandons the transaction; an IMemAck in the first cycle after reset release is accepted only for address RESET_PC.
REQ-031 IMemReq=1 in the first cycle after reset release.

Structure
REQ-032 Shared package fetch_pkg holds the FSM state enum, RESET_PC and NOP_WORD defaults, and the 32-bit word width constant.
REQ-033 One sub-module, fetch_skid_buffer (32-bit instruction plus 32-bit PC+4, load/drain/clear), instantiated once.
REQ-034 PC register, FSM and IF/ID register reside in instruction_fetch_stage.

Verification
REQ-035 Reset then IMemAck every cycle, data 0x11,0x22,0x33 -> IMemAddr 0,4,8; Instruction 0x11,0x22,0x33 on following cycles; PCPlus4 4,8,12.
REQ-036 Ack of 0xAA at PC=8 with Stall high for 3 cycles -> IMemReq low in HOLD, Instruction unchanged; Stall falls -> Instruction=0xAA, PCPlus4=12, next IMemAddr=12.
REQ-037 PCSrc with BranchTarget=0x103 while fetch at 0x10 unacked -> DRAIN, IMemAddr stays 0x10; on ack data discarded, next IMemAddr=0x100, InstrValid=0.
REQ-038 PCSrc=1 with Stall=1 and InstrValid=1 -> next cycle Instruction=NOP_WORD, InstrValid=0, IMemAddr=BranchTarget.
REQ-039 PC=0xFFFF_FFFC, ack -> PCPlus4=0x0000_0000, next IMemAddr=0.
REQ-040 Rst low in DRAIN with PendTarget=0x40 -> next cycle IMemAddr=RESET_PC, InstrValid=0, 0x40 never fetched.
